// File: rtl/axis_packet_source_if.sv
// AXI-Stream bundle used between the packet source and its sink.
// Master drives data/valid/last, slave drives ready.
interface axis_packet_source_if #(
  parameter int DATA_WIDTH = 128
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/axis_packet_source.sv
// AXI-Stream packet source: lane i of beat k = seed + k*LANES + i.
// Define SOURCE_GAP_INSERT_EN for LFSR-driven idle gaps between beats.
module axis_packet_source #(
  parameter int DATA_WIDTH = 128,
  parameter int LEN_WIDTH  = 16,
  parameter int GAP_LOG2   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] pkt_len,
  input  logic [31:0]          seed,
  axis_packet_source_if.master m_axis,
  output logic                 busy,
  output logic                 done,
  output logic [LEN_WIDTH-1:0] beat_count
);

  localparam int          NL    = DATA_WIDTH / 32;
  localparam logic [31:0] LANES = 32'(NL);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
`ifdef SOURCE_GAP_INSERT_EN
  localparam logic [1:0] ST_GAP  = 2'd2;
`endif

  if (DATA_WIDTH % 32 != 0 || DATA_WIDTH < 32) begin : g_dw_chk
    $error("DATA_WIDTH must be a positive multiple of 32");
  end
  if (GAP_LOG2 < 1 || GAP_LOG2 > 16) begin : g_gap_chk
    $error("GAP_LOG2 must be in 1..16");
  end

  function automatic logic [DATA_WIDTH-1:0] pat(
    input logic [31:0] b
  );
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < NL; i++) begin
      r[32*i +: 32] = b + 32'(i);
    end
    return r;
  endfunction

  logic [1:0]            state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  beat_q, beat_d;
  logic [31:0]           base_q, base_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  hs;
  logic [31:0]           nxt_base;

`ifdef SOURCE_GAP_INSERT_EN
  logic [15:0]         lfsr_q, lfsr_d;
  logic [GAP_LOG2-1:0] gap_q, gap_d;
  logic [GAP_LOG2-1:0] gap_s;
  logic [15:0]         lfsr_step;
`endif

  assign hs       = valid_q & m_axis.tready;
  assign nxt_base = base_q + LANES;

`ifdef SOURCE_GAP_INSERT_EN
  // x^16+x^14+x^13+x^11+1, shifting toward bit 0
  assign lfsr_step = {lfsr_q[0] ^ lfsr_q[2] ^
                      lfsr_q[3] ^ lfsr_q[5],
                      lfsr_q[15:1]};
  assign gap_s     = lfsr_q[GAP_LOG2-1:0];
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    beat_d  = beat_q;
    base_d  = base_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef SOURCE_GAP_INSERT_EN
    lfsr_d  = lfsr_q;
    gap_d   = gap_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start && pkt_len != '0) begin
          len_d   = pkt_len;
          beat_d  = '0;
          busy_d  = 1'b1;
          valid_d = 1'b1;
          last_d  = (pkt_len == LEN_WIDTH'(1));
          base_d  = seed;
          data_d  = pat(seed);
          state_d = ST_SEND;
`ifdef SOURCE_GAP_INSERT_EN
          lfsr_d  = (seed[15:0] == 16'h0) ?
                    16'hACE1 : seed[15:0];
`endif
        end else if (start) begin
          done_d = 1'b1;
        end
      end
      ST_SEND: begin
        if (hs) begin
          beat_d = beat_q + LEN_WIDTH'(1);
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            base_d = nxt_base;
            data_d = pat(nxt_base);
            // next beat is final when beat_q+1 == len-1
            last_d = (beat_q + LEN_WIDTH'(2)) == len_q;
`ifdef SOURCE_GAP_INSERT_EN
            lfsr_d = lfsr_step;
            if (gap_s != '0) begin
              valid_d = 1'b0;
              gap_d   = gap_s;
              state_d = ST_GAP;
            end
`endif
          end
        end
      end
`ifdef SOURCE_GAP_INSERT_EN
      ST_GAP: begin
        if (gap_q == GAP_LOG2'(1)) begin
          valid_d = 1'b1;
          state_d = ST_SEND;
        end else begin
          gap_d = gap_q - GAP_LOG2'(1);
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      beat_q  <= '0;
      base_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef SOURCE_GAP_INSERT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= 16'hACE1;
      gap_q  <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      gap_q  <= gap_d;
    end
  end
`endif

  assign m_axis.tdata  = data_q;
  assign m_axis.tvalid = valid_q;
  assign m_axis.tlast  = last_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign beat_count    = beat_q;

endmodule

// File: doc/axis_packet_source.md
Name: axis_packet_source

Overview:
- AXI-Stream master producing one packet of deterministic test words per start request.
- Transmit-side counterpart of the bench data consumer. Feeds the AES-256-CTR core's input stream in simulation and FPGA self-test.
- The word pattern is fully derivable from seed and beat index, so a checker can regenerate expected data without files.
- Optional pseudo-random idle gaps exercise the downstream tvalid handling.

Parameters:
DATA_WIDTH, 128, stream word width; multiple of 32.
LEN_WIDTH, 16, width of packet length in beats.
GAP_LOG2, 3, max idle gap is 2^GAP_LOG2-1 cycles (used only with the optional feature).

Ports:
clk  input  1  clock, all logic on rising edge.
rst  input  1  reset, asynchronous, active-high.
start  input  1  one-cycle request to send a packet; sampled only in IDLE.
pkt_len  input  LEN_WIDTH  packet length in beats, captured on accepted start.
seed  input  32  pattern seed, captured on accepted start.
m_axis_tdata  output  DATA_WIDTH  stream data.
m_axis_tvalid  output  1  stream valid.
m_axis_tlast  output  1  asserted with the final beat.
m_axis_tready  input  1  downstream ready.
busy  output  1  high from accepted start until done.
done  output  1  one-cycle pulse after last beat handshake.
beat_count  output  LEN_WIDTH  beats accepted so far in current packet.

Behaviour:
- Reset (async assert, sync release):
  - tvalid=0, tlast=0, tdata=0, busy=0, done=0, beat_count=0.
  - FSM goes to IDLE.
  - Reset mid-packet abandons the packet; no done pulse is generated.
- Handshake: a beat transfers when tvalid&&tready at a rising edge.
  - Once tvalid=1, tdata/tlast/tvalid stay stable until the handshake.
  - tvalid never depends combinationally on tready.
- Data pattern: LANES = DATA_WIDTH/32.
  - For beat k (0-based), lane i (bits 32i+31:32i) = seed + k*LANES + i, mod 2^32.
  - Lane 0 is least significant.
- FSM states IDLE, SEND, GAP:
  - IDLE:
    - start with pkt_len>0: capture pkt_len and seed, set busy=1, set beat_count=0, go to SEND.
    - tvalid rises in the cycle after start (latency 1).
    - start with pkt_len==0: no beats; done pulses the next cycle; busy stays 0; stay in IDLE.
  - SEND:
    - tvalid=1; tlast=1 iff beat_count==pkt_len-1.
    - On handshake: beat_count increments and the next beat's data is presented.
    - Back-to-back beats are allowed with no bubble (one beat per cycle at full throughput).
    - On the handshake of the tlast beat: tvalid=0, tlast=0, busy=0, done=1 for exactly one cycle, go to IDLE.
  - GAP: exists only with the optional feature; see below.
- start while busy is ignored and not queued.
- A new start is accepted earliest in the cycle in which done is high, because the FSM is already in IDLE.
- pkt_len=1: the single beat carries tlast=1.
- pkt_len = 2^LEN_WIDTH-1: beat_count reaches pkt_len with no wrap before done.
- Lane arithmetic wraps silently at 2^32.
- tready held low indefinitely: the current beat is held with no timeout.

Optional Feature:
Macro SOURCE_GAP_INSERT_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) is loaded on accepted start with seed[15:0], or 16'hACE1 if that is zero.
  - The LFSR steps once per non-final handshake.
  - After that handshake, gap = LFSR[GAP_LOG2-1:0] sampled before the step.
  - If gap>0: go to GAP with tvalid=0 for gap cycles, then return to SEND.
  - If gap==0: stay in SEND.
  - No gap is inserted after the last beat or before the first beat.
- Not defined: no GAP state and no LFSR. tvalid stays high for the whole packet except for tready stalls.

Test Plan:
1. seed=32'h0000_0010, pkt_len=3, tready=1 constantly, macro off -> tvalid high for 3 consecutive cycles starting the cycle after start. tdata = 0x00000013_00000012_00000011_00000010, 0x17..14, 0x1B..18. tlast only on the 3rd beat. done pulses once; busy falls with done.
2. Same packet with tready low for 4 cycles mid-beat 1 -> beat-1 tdata and tvalid stable across the stall; beat_count holds at 1; all 3 beats received.
3. pkt_len=1, seed=32'hFFFF_FFFE -> a single beat 0x00000001_00000000_FFFFFFFF_FFFFFFFE with tlast=1, showing wrap.
4. pkt_len=0 -> no tvalid ever asserted; done pulses 1 cycle after start; busy stays 0.
5. Assert rst asynchronously mid-packet (beat 2 of 5) -> tvalid, busy and tlast drop without a clock edge; no done pulse. A subsequent start sends beat 0 of the new seed.
6. Macro on, seed=32'h0000_0001, GAP_LOG2=3, pkt_len=8 -> gap lengths match the LFSR model; tvalid is never low between a non-handshaked assertion and its handshake; 8 beats arrive in order with tlast on the 8th.
